// File: rtl/cur_blk_streamer.sv
// Streams one parallel current block out as BEATS beats of BEAT_W bits over valid/ready.
// The block is copied into a shadow register at start, so BlockIN may change while a block is in flight.
module cur_blk_streamer #(
  parameter int BEATS  = 32,
  parameter int BEAT_W = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BEATS*BEAT_W-1:0]   BlockIN,
  input  logic                      ready,
  output logic [BEAT_W-1:0]         DataOUT,
  output logic                      valid,
  output logic                      last,
  output logic                      busy,
  output logic                      done
);

  localparam int BLK_W = BEATS * BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(BEATS - 2);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [BLK_W-1:0]   shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      shadow   <= '0;
      DataOUT  <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow   <= BlockIN;
            beat_cnt <= '0;
            DataOUT  <= BlockIN[BLK_W-1 -: BEAT_W];
            valid    <= 1'b1;
            busy     <= 1'b1;
            last     <= (BEATS == 1);
            state    <= SEND;
          end
        end
        SEND: begin
          if (ready) begin
            shadow <= shadow << BEAT_W;
            if (beat_cnt == LAST_CNT) begin
              state   <= DONE;
              DataOUT <= '0;
              valid   <= 1'b0;
              last    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              // outputs are registered, so preload the beat that follows the one being accepted
              beat_cnt <= beat_cnt + 1'b1;
              DataOUT  <= shadow[BLK_W-BEAT_W-1 -: BEAT_W];
              last     <= (beat_cnt == PRE_LAST);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cur_blk_streamer.sv
// Directed bench for cur_blk_streamer: reset/idle, streaming, backpressure, capture isolation,
// ignored start pulses and reset mid-block, against a block whose beat k is {8{k}}.
module tb_cur_blk_streamer;

  localparam int BEATS  = 32;
  localparam int BEAT_W = 64;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic [BEATS*BEAT_W-1:0] BlockIN = '0;
  logic                    ready = 1'b0;
  logic [BEAT_W-1:0]       DataOUT;
  logic                    valid, last, busy, done;

  logic [BEATS*BEAT_W-1:0] golden;
  int n_checks = 0;
  int n_fail   = 0;

  cur_blk_streamer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .BlockIN(BlockIN), .ready(ready),
    .DataOUT(DataOUT), .valid(valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_of(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {8{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"},  64'(busy),  64'd0);
    check({tag, "_done"},  64'(done),  64'd0);
    check({tag, "_last"},  64'(last),  64'd0);
    check({tag, "_data"},  DataOUT,    64'd0);
  endtask

  // Caller is positioned just after a rising edge. bp: ready pattern 1,0,0 repeating.
  // iso: BlockIN forced to all ones one cycle after start. ign: start pulsed at beat 10 and in DONE.
  // abort_at >= 0: reset asserted while beat abort_at is presented.
  task automatic run_block(input string tag, input bit bp, input bit iso, input bit ign,
                           input int abort_at);
    int k = 0;
    int cyc = 0;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    check({tag, "_pre_valid"}, 64'(valid), 64'd0);
    tick();
    start = 1'b0;
    if (iso) BlockIN = '1;
    while (k < BEATS && cyc < 300) begin
      ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (ign) start = (k == 10);
      @(negedge clk);
      check({tag, "_valid"}, 64'(valid), 64'd1);
      check({tag, "_busy"},  64'(busy),  64'd1);
      check({tag, "_done"},  64'(done),  64'd0);
      check({tag, "_last"},  64'(last),  64'(k == BEATS-1));
      check($sformatf("%s_beat%0d", tag, k), DataOUT, beat_of(k));
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        tick();
        @(negedge clk);
        check({tag, "_abort_valid"}, 64'(valid), 64'd0);
        check({tag, "_abort_busy"},  64'(busy),  64'd0);
        check({tag, "_abort_done"},  64'(done),  64'd0);
        tick();
        reset = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_quiet({tag, "_post_abort"});
          tick();
        end
        BlockIN = golden;
        return;
      end
      if (ready) k++;
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_beats_delivered"}, 64'(k), 64'(BEATS));
    if (ign) start = 1'b1;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done),  64'd1);
    check({tag, "_done_valid"}, 64'(valid), 64'd0);
    check({tag, "_done_busy"},  64'(busy),  64'd0);
    check({tag, "_done_last"},  64'(last),  64'd0);
    check({tag, "_done_data"},  DataOUT,    64'd0);
    tick();
    start = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_quiet({tag, "_after"});
      tick();
    end
    BlockIN = golden;
  endtask

  initial begin
    for (int k = 0; k < BEATS; k++) golden[BEATS*BEAT_W-1-BEAT_W*k -: BEAT_W] = beat_of(k);
    BlockIN = golden;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_quiet("idle");
      tick();
    end

    run_block("stream",   1'b0, 1'b0, 1'b0, -1);
    run_block("backpres", 1'b1, 1'b0, 1'b0, -1);
    run_block("isolate",  1'b0, 1'b1, 1'b0, -1);
    run_block("ign_start", 1'b0, 1'b0, 1'b1, -1);
    run_block("after_ign", 1'b0, 1'b0, 1'b0, -1);
    run_block("abort",    1'b0, 1'b0, 1'b0, 15);
    run_block("restart",  1'b1, 1'b0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cur_blk_streamer.md
Name: cur_blk_streamer

Overview:
- Serialises one 16x16x8-bit current block (2048 bits, held in parallel) into 32 beats of 64 bits using a valid/ready handshake.
- Sits on the read side of the current-block register file.
- Used to stream a captured block to memory, or to a downstream 64-bit write port.
- Beat order matches the register-file write order: beat 0 is block bits [2047:1984], beat 31 is bits [63:0].

Parameters:
- BEATS, 32, number of 64-bit beats per block.
- BEAT_W, 64, beat width in bits. Block width is BEATS*BEAT_W.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to capture BlockIN and stream it; sampled only in IDLE.
- BlockIN  input  2048  parallel block to transmit.
- ready  input  1  downstream can accept the current beat.
- DataOUT  output  64  current beat.
- valid  output  1  DataOUT holds a valid beat.
- last  output  1  high with valid on beat BEATS-1.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clock and reset
  - Single clock domain.
  - The reset check has priority over all other conditions on the rising edge of clk.
- Reset values
  - State = IDLE, beat_cnt = 0, shadow = 0.
  - DataOUT = 0, valid = 0, last = 0, busy = 0, done = 0.
  - Reset during SEND aborts the transfer immediately; no done pulse is issued.
- States: IDLE, SEND, DONE.
- IDLE
  - valid = 0, busy = 0.
  - When start = 1, capture BlockIN into a 2048-bit shadow register, set beat_cnt = 0, and go to SEND.
  - valid rises on the next cycle (latency start -> first valid = 1 cycle).
- SEND
  - valid = 1, busy = 1.
  - DataOUT = shadow[2047:1984].
  - last = (beat_cnt == BEATS-1).
  - A beat is transferred on a rising edge where valid && ready. On each transfer:
    - shadow shifts left by BEAT_W;
    - beat_cnt increments.
  - While ready = 0:
    - DataOUT, last and beat_cnt hold stable;
    - valid stays high and never drops mid-block.
  - Transfer with last = 1 goes to DONE.
- DONE
  - valid = 0, busy = 0, done = 1 for exactly one cycle.
  - Unconditionally return to IDLE.
  - start asserted in DONE is ignored; the next block is accepted only from IDLE.
  - Minimum spacing between start acceptances is therefore BEATS+2 cycles.
- start while in SEND or DONE is ignored; BlockIN changes after capture have no effect on the block in flight.
- beat_cnt is 5 bits (log2 BEATS) and is never allowed to wrap inside SEND.
  - The transition to DONE occurs exactly at count BEATS-1.
- DataOUT, valid and last are registered or derived only from registered state; there is no combinational path from ready or start to the outputs.
- When ready is held high, the 32 beats are contiguous cycles. This satisfies a downstream 64-bit writer whose write enable must stay asserted for all 32 beats; valid can drive such a write enable directly.
- DataOUT in IDLE/DONE is don't-care for consumers but is driven to 0.

Test Plan:
- Reset then idle: hold reset 2 cycles, release -> valid = busy = done = 0 and DataOUT = 0; no activity for 10 cycles without start.
- Back-to-back stream:
  - Stimulus: BlockIN with beat k = {8{k[7:0]}} (beat 0 in [2047:1984]), ready = 1, start pulsed at cycle 0.
  - Required: valid at cycles 1..32 with DataOUT = 0x0000000000000000, 0x0101010101010101, ... 0x1F1F1F1F1F1F1F1F; last only at cycle 32; done at cycle 33.
- Backpressure:
  - Stimulus: same block, ready toggled 1,0,0,1,...
  - Required: DataOUT holds while ready = 0; all 32 beats delivered once each, in order; done one cycle after the last transfer.
- Capture isolation: change BlockIN to all 0xFF one cycle after start -> streamed beats still match the original block.
- Ignored start: pulse start at beat 10 and in the DONE cycle -> no restart; exactly 32 beats; next start from IDLE streams normally.
- Reset mid-block: assert reset at beat 15 -> next cycle valid = 0, busy = 0, no done pulse; a fresh start then streams beat 0 first.
